fft_sequencer: RTL and testbench
================================

FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter N_2, default 11, meaning log2 of FFT points N; N_2 >= 2.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: begin a transform; sampled only in IDLE.
REQ-005 SHALL have port sample_valid, input, 1 bit: one input sample is presented this cycle (LOAD only).
REQ-006 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when the transform completes.
REQ-008 SHALL have port rdsel, output, 1 bit: 0 = butterfly reads RAM0, 1 = reads RAM1.
REQ-009 SHALL have ports we0 and we1, outputs, 1 bit each: butterfly write enables for RAM0 and RAM1.
REQ-010 SHALL have ports adr0a, adr0b, adr1a and adr1b, outputs, N_2 bits each: RAM port addresses.
REQ-011 SHALL have port twiddleadr, output, N_2-1 bits: twiddle ROM address (ROM output registered, 1-cycle latency).
REQ-012 SHALL have ports load_we (output, 1 bit) and load_adr (output, N_2 bits): sample write strobe and address into RAM0.

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, FLUSH and DONE.
REQ-014 SHALL transition IDLE->LOAD on start when FFT_SEQ_LOAD_EN is defined, else IDLE->RUN; LOAD->RUN after the N-th accepted sample; RUN->FLUSH after the last issue; FLUSH->DONE; DONE->IDLE. DONE lasts one cycle.
REQ-015 SHALL, in RUN, issue one butterfly per cycle: stage s from 0 to N_2-1 (outer), index j from 0 to N/2-1 (inner), N_2*N/2 issues in total, with no bubbles between stages.
REQ-016 SHALL compute, per issue: span = 2^s; ia = (j>>s)*2*span + (j & (span-1)); ib = ia+span; twiddleadr = (j & (span-1)) << (N_2-1-s), driven in the issue cycle.
REQ-017 SHALL register ia, ib and s once, so RAM addresses and write enables appear one cycle after the issue, aligned with the registered twiddle.
REQ-018 SHALL, in that aligned cycle, drive adr0a=adr1a=ia and adr0b=adr1b=ib, with rdsel=s[0], we1 = ~s[0] and we0 = s[0]; exactly one of we0/we1 is high.
REQ-019 SHALL drive we0=we1=0 in all other cycles, including IDLE, LOAD and DONE.
REQ-020 SHALL drive the last write during FLUSH and assert done during DONE; done therefore rises N_2*2^(N_2-1)+1 edges after the edge that samples start (macro off).
REQ-021 SHALL drive rdsel = N_2 mod 2 in IDLE and DONE, selecting the RAM holding the final result.
REQ-022 SHALL ignore start whenever it is not in IDLE; start held high across DONE SHALL begin a new transform from IDLE.
REQ-023 SHALL keep the stage and index counters and the aligned-cycle registers wrap-free: counters reset to 0 on entering RUN.

Reset
REQ-024 SHALL, while reset_n=0 (including mid-transform), go to IDLE and force busy, done, we0, we1 and load_we to 0, all addresses and twiddleadr to 0, and rdsel to N_2 mod 2.
REQ-025 SHALL, after reset_n deasserts, accept start no earlier than the first rising edge.

Configuration
REQ-026 SHALL, with FFT_SEQ_LOAD_EN defined, count sample_valid cycles in LOAD (count from 0), driving load_we=1 and load_adr = bit-reversed count in each such cycle; sample_valid outside LOAD SHALL be ignored.
REQ-027 SHALL, without FFT_SEQ_LOAD_EN, keep the LOAD state and its counter absent, tie load_we=0 and load_adr=0, and treat RAM0 as preloaded in bit-reversed order.

Structure
REQ-028 SHALL take its state enum and a bitrev function from a shared package fft_pkg.
REQ-029 SHALL place the REQ-016 address arithmetic in a combinational sub-module fft_butterfly_adr, with inputs (s, j) and outputs (ia, ib, twiddleadr).

Verification (N_2=3, N=8)
REQ-030 SHALL check: start pulse, macro off -> 12 issues, then done high 13 edges after the start edge for 1 cycle, with busy high between.
REQ-031 SHALL check: issue s=1,j=1 -> twiddleadr=2 in the issue cycle; next cycle adr*a=1, adr*b=3, rdsel=1, we0=1, we1=0.
REQ-032 SHALL check: issue s=2,j=3 -> twiddleadr=3, then ia=7-4=3, ib=7, we1=1; issue s=0,j=2 -> twiddleadr=0, ia=4, ib=5.
REQ-033 SHALL check: reset_n low at issue 6 -> same cycle busy=0 and we0=we1=0; after release a new start gives a full 13-edge run.
REQ-034 SHALL check: start held high through busy -> ignored; after DONE a second transform starts in IDLE the next cycle.
REQ-035 SHALL check: FFT_SEQ_LOAD_EN with 8 sample_valid pulses and gaps -> load_adr = 0,4,2,6,1,5,3,7, then RUN the cycle after the 8th.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg -- shared definitions for the FFT sequencer.
//   state_t : sequencer state encoding (LOAD exists only when FFT_SEQ_LOAD_EN
//             is defined).
//   bitrev  : reverses the low w bits of v (upper result bits are zero).
// Optional feature macro: FFT_SEQ_LOAD_EN.
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
`ifdef FFT_SEQ_LOAD_EN
    ST_LOAD  = 3'd1,
`endif
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[w-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly_adr.sv
// fft_butterfly_adr -- combinational radix-2 butterfly address generator.
//   s          : stage number (0 .. N_2-1)
//   j          : butterfly index within the stage (0 .. N/2-1)
//   ia, ib     : the two RAM addresses of the butterfly (ib = ia + 2^s)
//   twiddleadr : twiddle ROM address, (j mod 2^s) << (N_2-1-s)
module fft_butterfly_adr #(
  parameter int N_2 = 11,
  parameter int SW  = $clog2(N_2)
) (
  input  logic [SW-1:0]  s,
  input  logic [N_2-2:0] j,
  output logic [N_2-1:0] ia,
  output logic [N_2-1:0] ib,
  output logic [N_2-2:0] twiddleadr
);

  logic [N_2-1:0] span;
  logic [N_2-1:0] mask;
  logic [N_2-1:0] jx;

  always_comb begin
    span = N_2'(1) << s;
    mask = span - N_2'(1);
    jx   = {1'b0, j};
    // (j>>s)*2*span is just j with its low s bits cleared, shifted up one;
    // bit s of ia is therefore always zero, so ib can be formed with an OR.
    ia         = ((jx & ~mask) << 1) | (jx & mask);
    ib         = ia | span;
    twiddleadr = (j & mask[N_2-2:0]) << (SW'(N_2 - 1) - s);
  end

endmodule

// File: rtl/fft_sequencer.sv
// fft_sequencer -- control sequencer for an in-place radix-2 FFT that
// ping-pongs between two RAMs (stage s reads RAM s[0], writes the other).
//   clk, reset_n        : clock (rising edge), asynchronous active-low reset
//   start               : begin a transform (sampled in IDLE only)
//   sample_valid        : input sample strobe (used in LOAD only)
//   busy, done          : not-IDLE flag, one-cycle completion pulse
//   rdsel, we0, we1     : read RAM select and butterfly write enables
//   adr0a/b, adr1a/b    : RAM port addresses, valid in the write cycle
//   twiddleadr          : twiddle ROM address, one cycle ahead of the write
//   load_we, load_adr   : sample write strobe/bit-reversed address into RAM0
// Optional feature macro: FFT_SEQ_LOAD_EN adds the LOAD state; without it
// RAM0 is assumed preloaded in bit-reversed order.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int N_2 = 11
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           sample_valid,
  output logic           busy,
  output logic           done,
  output logic           rdsel,
  output logic           we0,
  output logic           we1,
  output logic [N_2-1:0] adr0a,
  output logic [N_2-1:0] adr0b,
  output logic [N_2-1:0] adr1a,
  output logic [N_2-1:0] adr1b,
  output logic [N_2-2:0] twiddleadr,
  output logic           load_we,
  output logic [N_2-1:0] load_adr
);

  localparam int   SW       = $clog2(N_2);
  localparam logic RD_FINAL = 1'(N_2 % 2);

  state_t         state;
  logic [SW-1:0]  stg;
  logic [N_2-2:0] idx;
  logic [N_2-1:0] ia_c, ib_c;
  logic [N_2-2:0] tw_c;
  logic           last_issue;

  // Issue-cycle values registered once so addresses line up with the
  // registered twiddle ROM output.
  logic           aval;
  logic [N_2-1:0] ia_q, ib_q;
  logic           s0_q;

  fft_butterfly_adr #(.N_2(N_2), .SW(SW)) u_adr (
    .s          (stg),
    .j          (idx),
    .ia         (ia_c),
    .ib         (ib_c),
    .twiddleadr (tw_c)
  );

  assign last_issue = (stg == SW'(N_2 - 1)) && (&idx);

`ifdef FFT_SEQ_LOAD_EN
  logic [N_2-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      stg   <= '0;
      idx   <= '0;
      done  <= 1'b0;
`ifdef FFT_SEQ_LOAD_EN
      cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
`ifdef FFT_SEQ_LOAD_EN
            state <= ST_LOAD;
            cnt   <= '0;
`else
            state <= ST_RUN;
`endif
            stg <= '0;
            idx <= '0;
          end
        end
`ifdef FFT_SEQ_LOAD_EN
        ST_LOAD: begin
          if (sample_valid) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
              state <= ST_RUN;
              stg   <= '0;
              idx   <= '0;
            end
          end
        end
`endif
        ST_RUN: begin
          // Counters park at zero after the last issue instead of wrapping.
          if (last_issue) begin
            state <= ST_FLUSH;
            stg   <= '0;
            idx   <= '0;
          end else if (&idx) begin
            idx <= '0;
            stg <= stg + 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_FLUSH: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aval <= 1'b0;
      ia_q <= '0;
      ib_q <= '0;
      s0_q <= 1'b0;
    end else if (state == ST_RUN) begin
      aval <= 1'b1;
      ia_q <= ia_c;
      ib_q <= ib_c;
      s0_q <= stg[0];
    end else begin
      aval <= 1'b0;
      ia_q <= '0;
      ib_q <= '0;
      s0_q <= 1'b0;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign twiddleadr = (state == ST_RUN) ? tw_c : '0;
  assign adr0a      = ia_q;
  assign adr1a      = ia_q;
  assign adr0b      = ib_q;
  assign adr1b      = ib_q;
  // Outside write cycles rdsel points at the RAM holding the final result.
  assign rdsel      = aval ? s0_q : RD_FINAL;
  assign we0        = aval & s0_q;
  assign we1        = aval & ~s0_q;

`ifdef FFT_SEQ_LOAD_EN
  assign load_we  = (state == ST_LOAD) && sample_valid;
  assign load_adr = N_2'(bitrev({{(32 - N_2){1'b0}}, cnt}, N_2));
`else
  logic unused_sample_valid;
  assign unused_sample_valid = sample_valid;
  assign load_we  = 1'b0;
  assign load_adr = '0;
`endif

endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer -- self-checking bench for fft_sequencer with N_2=3.
// A timeline model (edges since the transform began) predicts every output;
// a negedge process compares, and literal checks pin the model.
module tb_fft_sequencer;

  localparam int N_2 = 3;
  localparam int N   = 1 << N_2;
  localparam int NH  = N / 2;
  localparam int NI  = N_2 * NH;   // butterfly issues per transform
  localparam int KD  = NI + 1;     // edges from start to done

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           start = 1'b0;
  logic           sample_valid = 1'b0;
  logic           busy, done, rdsel, we0, we1, load_we;
  logic [N_2-1:0] adr0a, adr0b, adr1a, adr1b, load_adr;
  logic [N_2-2:0] twiddleadr;

  int checks = 0;
  int errors = 0;

  fft_sequencer #(.N_2(N_2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .rdsel        (rdsel),
    .we0          (we0),
    .we1          (we1),
    .adr0a        (adr0a),
    .adr0b        (adr0b),
    .adr1a        (adr1a),
    .adr1b        (adr1b),
    .twiddleadr   (twiddleadr),
    .load_we      (load_we),
    .load_adr     (load_adr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rev(input int c);
    int r;
    r = 0;
    for (int b = 0; b < N_2; b++) r = r * 2 + ((c >> b) & 1);
    return r;
  endfunction

  // Model: k = edges since the run began (-1 when idle); loading/lcnt track
  // sample acceptance.
  int k = -1;
  bit loading = 1'b0;
  int lcnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k = -1; loading = 1'b0; lcnt = 0;
    end else if (loading) begin
      if (sample_valid) begin
        lcnt++;
        if (lcnt == N) begin loading = 1'b0; k = 0; end
      end
    end else if (k < 0) begin
      if (start) begin
`ifdef FFT_SEQ_LOAD_EN
        loading = 1'b1; lcnt = 0;
`else
        k = 0;
`endif
      end
    end else if (k == KD) k = -1;
    else k++;
  end

  always @(negedge clk) begin : cmp
    int s, j, span, ia, ib, idle_st;
    idle_st = (k < 0 && !loading) ? 1 : 0;
    chk("busy", int'(busy), idle_st ? 0 : 1);
    chk("done", int'(done), (k == KD) ? 1 : 0);
    if (k >= 0 && k < NI) begin
      s = k / NH; j = k % NH; span = 1 << s;
      chk("twiddle", int'(twiddleadr), (j % span) * (1 << (N_2 - 1 - s)));
    end
    if (k >= 1 && k <= NI) begin
      s = (k - 1) / NH; j = (k - 1) % NH; span = 1 << s;
      ia = (j / span) * 2 * span + (j % span);
      ib = ia + span;
      chk("adr0a", int'(adr0a), ia);
      chk("adr1a", int'(adr1a), ia);
      chk("adr0b", int'(adr0b), ib);
      chk("adr1b", int'(adr1b), ib);
      chk("rdsel", int'(rdsel), s % 2);
      chk("we0", int'(we0), s % 2);
      chk("we1", int'(we1), 1 - s % 2);
    end else begin
      chk("we0_idle", int'(we0), 0);
      chk("we1_idle", int'(we1), 0);
      if (idle_st != 0 || k == KD) chk("rdsel_final", int'(rdsel), N_2 % 2);
    end
    if (!reset_n) begin
      chk("rst_adr", int'({adr0a, adr0b, adr1a, adr1b}), 0);
      chk("rst_twiddle", int'(twiddleadr), 0);
    end
`ifdef FFT_SEQ_LOAD_EN
    chk("load_we", int'(load_we), (loading && sample_valid) ? 1 : 0);
    if (loading && sample_valid) chk("load_adr", int'(load_adr), rev(lcnt));
`else
    chk("load_we", int'(load_we), 0);
    chk("load_adr", int'(load_adr), 0);
`endif
    // Hand-computed pins for N_2=3.
    if (k == 2)  chk("lit_tw_s0j2", int'(twiddleadr), 0);
    if (k == 3) begin
      chk("lit_ia_s0j2", int'(adr0a), 4);
      chk("lit_ib_s0j2", int'(adr1b), 5);
    end
    if (k == 5)  chk("lit_tw_s1j1", int'(twiddleadr), 2);
    if (k == 6) begin
      chk("lit_ia_s1j1", int'(adr1a), 1);
      chk("lit_ib_s1j1", int'(adr0b), 3);
      chk("lit_rdsel_s1j1", int'(rdsel), 1);
      chk("lit_we0_s1j1", int'(we0), 1);
      chk("lit_we1_s1j1", int'(we1), 0);
    end
    if (k == 11) chk("lit_tw_s2j3", int'(twiddleadr), 3);
    if (k == 12) begin
      chk("lit_ia_s2j3", int'(adr0a), 3);
      chk("lit_ib_s2j3", int'(adr0b), 7);
      chk("lit_we1_s2j3", int'(we1), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_samples(input bit lit);
    int exp_lr [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      sample_valid = 1'b1;
      #1;
      if (lit) chk("lit_load_adr", int'(load_adr), exp_lr[i]);
      tick();
      sample_valid = 1'b0;
    end
  endtask

  // Returns one time unit after the edge from which the run is counted.
  task automatic start_tx(input bit lit);
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef FFT_SEQ_LOAD_EN
    feed_samples(lit);
`else
    if (lit) chk("lit_busy_after_start", int'(busy), 1);
`endif
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit abort;
    int abort_k;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rdsel", int'(rdsel), 1);
    chk("rst_we", int'({we0, we1, load_we}), 0);
    reset_n = 1'b1;
    tick();

    // Single transform, done latency.
    start_tx(1'b1);
    wait_done(n);
    chk("lit_done_latency", n, KD);
    tick(); tick();

    // Reset in the middle of issue 6.
    start_tx(1'b0);
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    chk("abort6_busy", int'(busy), 0);
    chk("abort6_we0", int'(we0), 0);
    chk("abort6_we1", int'(we1), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    start_tx(1'b0);
    wait_done(n);
    chk("lit_done_after_reset", n, KD);
    tick();

    // Start held high: ignored while busy, restarts from IDLE after DONE.
    start = 1'b1;
    tick();
`ifdef FFT_SEQ_LOAD_EN
    feed_samples(1'b0);
`endif
    wait_done(n);
    chk("lit_held_first", n, KD);
    tick();
    chk("held_idle_busy", int'(busy), 0);
    tick();
    chk("held_restart_busy", int'(busy), 1);
    start = 1'b0;
`ifdef FFT_SEQ_LOAD_EN
    feed_samples(1'b0);
`endif
    wait_done(n);
    chk("lit_held_second", n, KD);
    tick(); tick();

    // Randomized transforms with start/sample noise and occasional aborts.
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 3)) tick();
      abort   = ($urandom_range(0, 4) == 0);
      abort_k = $urandom_range(0, KD);
      start_tx(1'b0);
      n = 0;
      while ((k >= 0 || loading) && n < 100) begin
        if (abort && k == abort_k) begin
          start = 1'b0;
          reset_n = 1'b0;
          #1;
          chk("abort_busy", int'(busy), 0);
          chk("abort_we", int'({we0, we1}), 0);
          chk("abort_done", int'(done), 0);
          tick();
          reset_n = 1'b1;
        end
        start = (k >= 0 && k < NI && $urandom_range(0, 3) == 0);
        sample_valid = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      start = 1'b0;
      sample_valid = 1'b0;
      chk("rand_run_ended", (n < 100) ? 1 : 0, 1);
    end

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
